// File: rtl/mine_pkg.sv
// Shared constants and state encoding for the mine placement sequencer.
package mine_pkg;
  localparam int BOARD_CELLS = 25;
  localparam int CELL_W      = 5;

  localparam logic [CELL_W-1:0] NO_SAFE = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/lcg_next.sv
// Combinational LCG step: y = (a*x + c) mod BOARD_CELLS.
module lcg_next
  import mine_pkg::*;
(
  input  logic [CELL_W-1:0] a,
  input  logic [CELL_W-1:0] c,
  input  logic [CELL_W-1:0] x,
  output logic [CELL_W-1:0] y
);
  logic [9:0] sum;

  // full 10-bit product plus increment, reduced exactly
  always_comb begin
    sum = 10'(a) * 10'(x) + 10'(c);
    y   = CELL_W'(sum % 10'(BOARD_CELLS));
  end
endmodule

// File: rtl/mine_placer_ctrl.sv
// Places N distinct mines on a 5x5 board via LCG with linear probing,
// never touching the first-click safe cell.
module mine_placer_ctrl
  import mine_pkg::*;
(
  input  logic                   in_clka,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic [CELL_W-1:0]      in_mult,
  input  logic [CELL_W-1:0]      in_increment,
  input  logic [CELL_W-1:0]      in_seed,
  input  logic [CELL_W-1:0]      in_mines_num,
  input  logic [CELL_W-1:0]      in_safe_cell,
  output logic [BOARD_CELLS-1:0] out_mines,
  output logic                   out_busy,
  output logic                   out_done,
  output logic [CELL_W-1:0]      out_mine_count,
  output logic                   out_error
);
  state_e state_q, state_d;

  logic [CELL_W-1:0] x_q, x_d;
  logic [CELL_W-1:0] a_q, a_d;
  logic [CELL_W-1:0] c_q, c_d;
  logic [CELL_W-1:0] safe_q, safe_d;
  logic [CELL_W-1:0] cnt_q, cnt_d;
  logic [CELL_W-1:0] tgt_q, tgt_d;
  logic [BOARD_CELLS-1:0] mines_q, mines_d;
  logic err_q, err_d;

  logic [CELL_W-1:0] x_lcg;
  logic [CELL_W-1:0] x_probe;
  logic [CELL_W-1:0] seed_m;
  logic [CELL_W-1:0] avail;
  logic              cand_ok;

  lcg_next u_lcg (
    .a(a_q),
    .c(c_q),
    .x(x_q),
    .y(x_lcg)
  );

  assign seed_m  = in_seed % CELL_W'(BOARD_CELLS);
  assign x_probe = (x_q == CELL_W'(BOARD_CELLS - 1))
                 ? '0 : x_q + 1'b1;
  assign cand_ok = !mines_q[x_q] && (x_q != safe_q);
  assign avail   = (in_safe_cell < NO_SAFE)
                 ? CELL_W'(BOARD_CELLS - 1)
                 : CELL_W'(BOARD_CELLS);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    c_d     = c_q;
    safe_d  = safe_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    mines_d = mines_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_start) state_d = LOAD;
      end
      LOAD: begin
        a_d     = in_mult;
        c_d     = in_increment;
        safe_d  = in_safe_cell;
        x_d     = seed_m;
        mines_d = '0;
        cnt_d   = '0;
        err_d   = in_mines_num > avail;
        tgt_d   = err_d ? avail : in_mines_num;
        state_d = (tgt_d == '0) ? DONE : PLACE;
      end
      PLACE: begin
        if (cand_ok) begin
          mines_d[x_q] = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          x_d          = x_lcg;
          if (cnt_d == tgt_q) state_d = DONE;
        end else begin
          x_d = x_probe;
        end
      end
      DONE: begin
        // a restart wipes the previous board as soon as it is accepted
        if (in_start) begin
          state_d = LOAD;
          mines_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      c_q     <= '0;
      safe_q  <= NO_SAFE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      mines_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      c_q     <= c_d;
      safe_q  <= safe_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      mines_q <= mines_d;
      err_q   <= err_d;
    end
  end

  assign out_mines      = mines_q;
  assign out_mine_count = cnt_q;
  assign out_error      = err_q;
  assign out_busy       = (state_q == LOAD) || (state_q == PLACE);
  assign out_done       = (state_q == DONE);
endmodule

// File: tb/tb_mine_placer_ctrl.sv
// Randomized and directed checks of mine_placer_ctrl against a
// behavioural placement model.
module tb_mine_placer_ctrl;
  logic        in_clka = 1'b0;
  logic        in_reset = 1'b0;
  logic        in_start = 1'b0;
  logic [4:0]  in_mult = '0;
  logic [4:0]  in_increment = '0;
  logic [4:0]  in_seed = '0;
  logic [4:0]  in_mines_num = '0;
  logic [4:0]  in_safe_cell = '0;
  logic [24:0] out_mines;
  logic        out_busy;
  logic        out_done;
  logic [4:0]  out_mine_count;
  logic        out_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 in_clka = ~in_clka;

  mine_placer_ctrl dut (
    .in_clka(in_clka),
    .in_reset(in_reset),
    .in_start(in_start),
    .in_mult(in_mult),
    .in_increment(in_increment),
    .in_seed(in_seed),
    .in_mines_num(in_mines_num),
    .in_safe_cell(in_safe_cell),
    .out_mines(out_mines),
    .out_busy(out_busy),
    .out_done(out_done),
    .out_mine_count(out_mine_count),
    .out_error(out_error)
  );

  // Board-level model: walk the generator, skipping taken/safe cells.
  task automatic model(input int seed, input int a, input int c,
                       input int n, input int safe,
                       output logic [24:0] m, output int cnt,
                       output int lat, output logic err);
    int x, avail, tgt;
    bit occ[25];
    for (int k = 0; k < 25; k++) occ[k] = 0;
    m = '0;
    cnt = 0;
    x = seed % 25;
    avail = (safe < 25) ? 24 : 25;
    err = (n > avail);
    tgt = err ? avail : n;
    lat = 1;
    while (cnt < tgt && lat < 1000) begin
      if (!occ[x] && x != safe) begin
        occ[x] = 1;
        m[x] = 1'b1;
        cnt++;
        x = (a * x + c) % 25;
      end else begin
        x = (x + 1) % 25;
      end
      lat++;
    end
  endtask

  task automatic run_case(input string nm, input int seed, input int a,
                          input int c, input int n, input int safe,
                          input bit scramble, input bit pulse_mid,
                          output logic [24:0] got, output int got_lat);
    logic [24:0] em;
    int ecnt, elat;
    logic eerr;
    model(seed, a, c, n, safe, em, ecnt, elat, eerr);
    @(posedge in_clka); #1;
    in_seed = 5'(seed);
    in_mult = 5'(a);
    in_increment = 5'(c);
    in_mines_num = 5'(n);
    in_safe_cell = 5'(safe);
    in_start = 1'b1;
    @(posedge in_clka); #1;
    in_start = 1'b0;
    n_cmp++;
    if (out_busy !== 1'b1 || out_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s load_flags busy=%b done=%b want 1/0",
               nm, out_busy, out_done);
    end
    got_lat = 0;
    got = 'x;
    forever begin
      @(posedge in_clka); #1;
      got_lat++;
      in_start = 1'b0;
      if (scramble && got_lat == 1) begin
        in_seed = 5'($urandom);
        in_mult = 5'($urandom);
        in_increment = 5'($urandom);
        in_mines_num = 5'($urandom);
        in_safe_cell = 5'($urandom);
      end
      if (pulse_mid && got_lat == 2 && elat > 3) in_start = 1'b1;
      if (out_done) break;
      if (got_lat >= 700) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout got no done want done", nm);
        return;
      end
    end
    got = out_mines;
    n_cmp++;
    if (got_lat != elat) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", nm, got_lat, elat);
    end
    n_cmp++;
    if (out_mines !== em) begin
      n_bad++;
      $display("FAIL %s mines got %h want %h", nm, out_mines, em);
    end
    n_cmp++;
    if (out_mine_count !== 5'(ecnt) || out_error !== eerr
        || out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s cnt/err/busy got %0d/%b/%b want %0d/%b/0",
               nm, out_mine_count, out_error, out_busy, ecnt, eerr);
    end
    repeat (2) @(posedge in_clka);
    #1;
    n_cmp++;
    if (out_mines !== em || out_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s hold got %h/%b want %h/1",
               nm, out_mines, out_done, em);
    end
  endtask

  task automatic test_reset();
    #2 in_reset = 1'b1;
    repeat (2) @(posedge in_clka);
    #1;
    n_cmp++;
    if (out_mines !== '0 || out_mine_count !== '0 || out_busy !== 1'b0
        || out_done !== 1'b0 || out_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset outs got %h/%0d/%b/%b/%b want all 0",
               out_mines, out_mine_count, out_busy, out_done, out_error);
    end
    in_reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [24:0] g;
    int l;
    run_case("inc_lcg", 0, 1, 1, 3, 31, 0, 0, g, l);
    n_cmp++;
    if (g !== 25'h0000007 || l != 4) begin
      n_bad++;
      $display("FAIL inc_lcg_const got %h/%0d want 0000007/4", g, l);
    end
    run_case("zero_lcg", 5, 0, 0, 3, 31, 0, 0, g, l);
    n_cmp++;
    if (g !== 25'h0000023 || l != 5) begin
      n_bad++;
      $display("FAIL zero_lcg_const got %h/%0d want 0000023/5", g, l);
    end
    run_case("safe0", 0, 1, 1, 2, 0, 0, 0, g, l);
    n_cmp++;
    if (g !== 25'h0000006) begin
      n_bad++;
      $display("FAIL safe0_const got %h want 0000006", g);
    end
    run_case("clamp", 4, 7, 3, 30, 12, 0, 0, g, l);
    n_cmp++;
    if (g !== 25'h1FFEFFF || out_error !== 1'b1
        || out_mine_count !== 5'd24) begin
      n_bad++;
      $display("FAIL clamp_const got %h/%b/%0d want 1ffefff/1/24",
               g, out_error, out_mine_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] g;
    int l;
    @(posedge in_clka); #1;
    in_seed = 5'd3;
    in_mult = 5'd11;
    in_increment = 5'd2;
    in_mines_num = 5'd20;
    in_safe_cell = 5'd7;
    in_start = 1'b1;
    @(posedge in_clka); #1;
    in_start = 1'b0;
    repeat (4) @(posedge in_clka);
    #3 in_reset = 1'b1;
    #1;
    n_cmp++;
    if (out_mines !== '0 || out_mine_count !== '0 || out_busy !== 1'b0
        || out_done !== 1'b0 || out_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got %h/%0d/%b/%b/%b want all 0",
               out_mines, out_mine_count, out_busy, out_done, out_error);
    end
    @(posedge in_clka); #1;
    in_reset = 1'b0;
    run_case("after_reset", 3, 11, 2, 20, 7, 0, 0, g, l);
  endtask

  task automatic test_start_ignored();
    logic [24:0] g;
    int l;
    run_case("mid_start", 9, 3, 7, 10, 31, 0, 1, g, l);
    run_case("restart_n0", 9, 3, 7, 0, 31, 0, 0, g, l);
    n_cmp++;
    if (g !== '0 || l != 1) begin
      n_bad++;
      $display("FAIL restart_n0_const got %h/%0d want 0/1", g, l);
    end
  endtask

  task automatic test_random();
    logic [24:0] g;
    int l;
    for (int i = 0; i < 40; i++) begin
      run_case($sformatf("rnd%0d", i),
               int'($urandom_range(31)), int'($urandom_range(31)),
               int'($urandom_range(31)), int'($urandom_range(31)),
               int'($urandom_range(31)), 1, i[0], g, l);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mine_placer_ctrl.md
Name: mine_placer_ctrl

Overview:
Sequencer that fills the 25-cell (5x5) Minesweeper board with mines using the linear congruential generator X[n+1] = (a*X[n] + c) mod 25. It guarantees exactly N distinct mines and never places a mine on the player's first-click cell. Collisions and safe-cell hits are resolved by linear probing. It sits between the game FSM and the board register, which consumes out_mines.

Parameters:
BOARD_CELLS, 25, number of board cells; also the LCG modulus.
CELL_W, 5, width of a cell index.

Ports:
in_clka  input  1  system clock; all state updates on negedge.
in_reset  input  1  asynchronous, active-high reset.
in_start  input  1  start request; one-cycle pulse or level.
in_mult  input  5  LCG multiplier a.
in_increment  input  5  LCG increment c.
in_seed  input  5  initial X; reduced mod 25 at load.
in_mines_num  input  5  requested mine count N.
in_safe_cell  input  5  cell excluded from placement; a value of 25 or more means no exclusion.
out_mines  output  25  mine bitmap; bit k set means a mine in cell k.
out_busy  output  1  high in LOAD and PLACE.
out_done  output  1  high in DONE until the next accepted start.
out_mine_count  output  5  mines placed so far.
out_error  output  1  N was clamped; sticky until the next accepted start.

Behaviour:
- Clock and reset: single clock, in_clka, with all flops on its negedge. in_reset is asynchronous and active-high.
- Reset values: state=IDLE; out_mines=0; out_mine_count=0; out_busy=0; out_done=0; out_error=0; X=0.
- IDLE: if in_start=1, go to LOAD. Otherwise hold.
- LOAD (1 cycle):
  - Latch a, c and safe_cell.
  - X = in_seed mod 25.
  - Clear out_mines and out_mine_count.
  - avail = 24 if safe_cell<25, else 25.
  - target = min(N, avail); out_error = (N > avail).
  - If target=0, go to DONE; else go to PLACE.
- PLACE: exactly one candidate per cycle, cand = X.
  - If cand is free and cand != safe_cell: set out_mines[cand], increment count, X = (a*X + c) mod 25.
  - Otherwise (collision or safe cell): X = (X+1) mod 25, with 24 wrapping to 0. Nothing is placed.
  - When the count reaches target on this cycle's placement, go to DONE next cycle.
- DONE: out_done=1 and out_mines held stable. in_start=1 goes to LOAD (restart).
- in_start during LOAD or PLACE is ignored.
- Arithmetic:
  - The product a*X is 10 bits (max 31*24=744); adding c gives max 775, still 10 bits.
  - mod 25 is exact and combinational. No truncation before the mod.
- Termination: while count < target a free, non-safe cell always exists. The probe therefore finds one within 25 cycles, so latency is at most 1 + 25*target cycles. For an LCG with no collisions, latency is 1 + target.
- Degenerate LCG (a=0, c=0, or a short cycle): correctness comes from probing alone. No lock-up is permitted.
- Reset mid-operation: immediate return to reset values. The partial bitmap is discarded.
- in_mines_num, in_mult, in_increment and in_seed may change after LOAD without effect.

Decomposition:
- Package mine_pkg: BOARD_CELLS=25, CELL_W=5, NO_SAFE=25, and the state encoding IDLE/LOAD/PLACE/DONE (2 bits).
- Sub-module lcg_next: combinational; inputs a, c, x; output (a*x+c) mod 25.
- The controller instantiates lcg_next once.

Test Plan:
1. Reset asserted mid-PLACE -> all outputs are 0 within the same cycle; state=IDLE; a following start runs normally.
2. seed=0, a=1, c=1, N=3, safe=31 -> out_mines=0x0000007, count=3; out_done rises 4 cycles after start is sampled; out_error=0.
3. seed=5, a=0, c=0, N=3, safe=31 -> places 5, then 0, then collides at 0, probes 1 and places it -> out_mines=0x0000023; 5 cycles from start to DONE.
4. seed=0, a=1, c=1, N=2, safe=0 -> cell 0 is skipped and the probe goes to 1; then 2 -> out_mines=0x0000006; bit 0 is never set.
5. N=30, safe=12, a=7, c=3, seed=4 -> 24 mines, out_mines=0x1FFEFFF, out_error=1; the first placement is cell 4, followed by X=(28+3) mod 25=6.
6. Start pulsed during PLACE, then restart from DONE with N=0 -> the start during PLACE is ignored; the restart gives out_mines=0 and out_done=1 one cycle after LOAD.
